// File: rtl/scan_pkg.sv
// Shared types and helpers for the one-hot scan sequencer.
package scan_pkg;

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } scan_state_t;

  localparam int MAX_CH = 32;

  // Index width, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_CH-1:0] onehot(input int unsigned idx);
    return {{(MAX_CH-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Prescaler that emits a single-cycle tick every PRESCALE enabled clocks.
module scan_tick_gen #(
  parameter int PRESCALE = 50000
) (
  input  logic iclk,
  input  logic ireset,
  input  logic ien,
  output logic otick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count;

  assign otick = ien && (count == LAST);

  // Count only while enabled; a disabled prescaler keeps its position.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      count <= '0;
    end else if (ien) begin
      count <= otick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/scan_onehot_seq.sv
// One-hot scan sequencer: steps through enabled channels with optional blanking gap.
module scan_onehot_seq
  import scan_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 0,
  parameter bit SEL_ACT_LOW  = 1'b0
) (
  input  logic                       iclk,
  input  logic                       ireset,
  input  logic                       icle,
  input  logic                       idir,
  input  logic [N_CH-1:0]            ivmask,
  output logic [N_CH-1:0]            ovsel,
  output logic [idx_width(N_CH)-1:0] ovidx,
  output logic                       oblank,
  output logic                       oframe
);

  localparam int IW = idx_width(N_CH);
  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  scan_state_t   state, state_nx;
  logic [IW-1:0] idx, idx_nx, next_idx;
  logic [BW-1:0] bcnt, bcnt_nx;
  logic          tick;
  logic          advance;
  logic          frame_nx;
  logic [N_CH-1:0] sel;

  scan_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .iclk  (iclk),
    .ireset(ireset),
    .ien   (icle && (state == SHOW)),
    .otick (tick)
  );

  // Nearest enabled channel in the scan direction; the current channel is the last resort.
  always_comb begin
    int            cand;
    logic [IW-1:0] cidx;
    next_idx = idx;
    cand     = 0;
    cidx     = '0;
    for (int k = N_CH; k >= 1; k--) begin
      cand = idir ? int'(idx) - k : int'(idx) + k;
      if (cand < 0) begin
        cand = cand + N_CH;
      end else if (cand >= N_CH) begin
        cand = cand - N_CH;
      end
      cidx = IW'(cand);
      if (ivmask[cidx]) begin
        next_idx = cidx;
      end
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    bcnt_nx  = bcnt;
    advance  = 1'b0;
    case (state)
      SHOW: begin
        if (tick) begin
          if (BLANK_CYCLES == 0) begin
            advance = 1'b1;
          end else begin
            state_nx = BLANK;
            bcnt_nx  = '0;
          end
        end
      end
      BLANK: begin
        if (bcnt == BW'(BLANK_CYCLES - 1)) begin
          advance  = 1'b1;
          state_nx = SHOW;
        end else begin
          bcnt_nx = bcnt + 1'b1;
        end
      end
      default: state_nx = SHOW;
    endcase
    if (advance) begin
      idx_nx = next_idx;
    end
    // A wrap is any advance that does not move strictly forward in the scan direction.
    frame_nx = advance && (|ivmask) &&
               (idir ? (next_idx >= idx) : (next_idx <= idx));
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state  <= SHOW;
      idx    <= '0;
      bcnt   <= '0;
      oframe <= 1'b0;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      bcnt   <= bcnt_nx;
      oframe <= frame_nx;
    end
  end

  // Mask gates the select live so a disabled channel goes dark without waiting for a step.
  always_comb begin
    sel    = '0;
    oblank = 1'b1;
    if (state == SHOW) begin
      sel    = N_CH'(onehot(32'(idx))) & ivmask;
      oblank = ~ivmask[idx];
    end
    ovsel = SEL_ACT_LOW ? ~sel : sel;
  end

  assign ovidx = idx;

endmodule

// File: tb/tb_scan_onehot_seq.sv
// Randomised self-checking bench for scan_onehot_seq against a per-channel behavioural model.
module tb_scan_onehot_seq;

  localparam int NI = 3;
  localparam int NCH [NI] = '{4, 4, 5};
  localparam int PRE [NI] = '{3, 3, 2};
  localparam int BLK [NI] = '{0, 2, 1};
  localparam int LOW [NI] = '{0, 0, 1};

  logic clk = 1'b0;
  logic ireset, icle, idir;
  int   mk [NI];

  logic [3:0] mask0, mask1, sel0, sel1;
  logic [4:0] mask2, sel2;
  logic [1:0] idx0, idx1;
  logic [2:0] idx2;
  logic       blank0, blank1, blank2, frame0, frame1, frame2;

  int m_idx [NI];
  int m_cnt [NI];
  int m_blank [NI];
  int m_frame [NI];

  int tests = 0;
  int fails = 0;

  assign mask0 = mk[0][3:0];
  assign mask1 = mk[1][3:0];
  assign mask2 = mk[2][4:0];

  always #5 clk = ~clk;

  scan_onehot_seq #(.N_CH(4), .PRESCALE(3), .BLANK_CYCLES(0), .SEL_ACT_LOW(1'b0)) u0 (
    .iclk(clk), .ireset(ireset), .icle(icle), .idir(idir), .ivmask(mask0),
    .ovsel(sel0), .ovidx(idx0), .oblank(blank0), .oframe(frame0));

  scan_onehot_seq #(.N_CH(4), .PRESCALE(3), .BLANK_CYCLES(2), .SEL_ACT_LOW(1'b0)) u1 (
    .iclk(clk), .ireset(ireset), .icle(icle), .idir(idir), .ivmask(mask1),
    .ovsel(sel1), .ovidx(idx1), .oblank(blank1), .oframe(frame1));

  scan_onehot_seq #(.N_CH(5), .PRESCALE(2), .BLANK_CYCLES(1), .SEL_ACT_LOW(1'b1)) u2 (
    .iclk(clk), .ireset(ireset), .icle(icle), .idir(idir), .ivmask(mask2),
    .ovsel(sel2), .ovidx(idx2), .oblank(blank2), .oframe(frame2));

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obsSel(input int i);
    case (i)
      0: return 32'(sel0);
      1: return 32'(sel1);
      default: return 32'(sel2);
    endcase
  endfunction

  function automatic logic [31:0] obsIdx(input int i);
    case (i)
      0: return 32'(idx0);
      1: return 32'(idx1);
      default: return 32'(idx2);
    endcase
  endfunction

  function automatic logic [31:0] obsBlank(input int i);
    case (i)
      0: return 32'(blank0);
      1: return 32'(blank1);
      default: return 32'(blank2);
    endcase
  endfunction

  function automatic logic [31:0] obsFrame(input int i);
    case (i)
      0: return 32'(frame0);
      1: return 32'(frame1);
      default: return 32'(frame2);
    endcase
  endfunction

  function automatic int chanOn(input int i);
    return (mk[i] >> m_idx[i]) & 1;
  endfunction

  function automatic int expSel(input int i);
    int s;
    s = 0;
    if (m_blank[i] == 0 && chanOn(i) != 0) s = 1 << m_idx[i];
    if (LOW[i] != 0) s = s ^ ((1 << NCH[i]) - 1);
    return s;
  endfunction

  function automatic int expBlank(input int i);
    return (m_blank[i] != 0 || chanOn(i) == 0) ? 1 : 0;
  endfunction

  task automatic resetModel();
    for (int i = 0; i < NI; i++) begin
      m_idx[i]   = 0;
      m_cnt[i]   = 0;
      m_blank[i] = 0;
      m_frame[i] = 0;
    end
  endtask

  // One clock of the behavioural model: pace, optional gap, then search the mask for the next channel.
  task automatic modelStep(input int i);
    int adv, old, c;
    adv = 0;
    m_frame[i] = 0;
    if (m_blank[i] > 0) begin
      m_blank[i]--;
      adv = (m_blank[i] == 0) ? 1 : 0;
    end else if (icle) begin
      if (m_cnt[i] == PRE[i] - 1) begin
        m_cnt[i] = 0;
        if (BLK[i] == 0) adv = 1;
        else m_blank[i] = BLK[i];
      end else begin
        m_cnt[i]++;
      end
    end
    if (adv != 0 && mk[i] != 0) begin
      old = m_idx[i];
      for (int k = 1; k <= NCH[i]; k++) begin
        c = idir ? (old - k + NCH[i]) % NCH[i] : (old + k) % NCH[i];
        if (((mk[i] >> c) & 1) != 0) begin
          m_idx[i] = c;
          break;
        end
      end
      m_frame[i] = idir ? int'(m_idx[i] >= old) : int'(m_idx[i] <= old);
    end
  endtask

  task automatic checkAll(input string phase);
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("%s u%0d sel", phase, i), obsSel(i), 32'(expSel(i)));
      checkOutput($sformatf("%s u%0d idx", phase, i), obsIdx(i), 32'(m_idx[i]));
      checkOutput($sformatf("%s u%0d blank", phase, i), obsBlank(i), 32'(expBlank(i)));
      checkOutput($sformatf("%s u%0d frame", phase, i), obsFrame(i), 32'(m_frame[i]));
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic applyStimulus(input string phase, input bit cle, input bit dir,
                               input int m0, input int m1, input int m2);
    icle  = cle;
    idir  = dir;
    mk[0] = m0 & 'hF;
    mk[1] = m1 & 'hF;
    mk[2] = m2 & 'h1F;
    #1 checkAll({phase, " pre"});
    @(posedge clk);
    if (!ireset) begin
      for (int i = 0; i < NI; i++) modelStep(i);
    end
    #1 checkAll({phase, " post"});
    @(negedge clk);
  endtask

  initial begin
    int found;
    bit dir;
    int r0, r1, r2;
    ireset = 1'b1;
    icle   = 1'b0;
    idir   = 1'b0;
    mk[0]  = 'hF;
    mk[1]  = 'hF;
    mk[2]  = 'h1F;
    resetModel();
    #3 checkAll("reset");
    checkOutput("reset u2 active-low sel", 32'(sel2), 32'h1E);
    @(negedge clk);
    ireset = 1'b0;

    repeat (14) applyStimulus("T1", 1'b1, 1'b0, 'hF, 'hF, 'h1F);
    repeat (14) applyStimulus("T2", 1'b1, 1'b1, 'hF, 'hF, 'h1F);
    repeat (12) applyStimulus("T3", 1'b1, 1'b0, 'hA, 'hA, 'hA);
    repeat (8)  applyStimulus("T3 zero", 1'b1, 1'b0, 0, 0, 0);
    for (int j = 0; j < 30; j++) begin
      applyStimulus("T4", (j % 5) < 3, 1'b0, 'hF, 'hF, 'h1F);
    end
    repeat (6) applyStimulus("single", 1'b1, 1'b1, 'h4, 'h2, 'h8);

    dir = 1'b0;
    r0 = 'hF; r1 = 'hF; r2 = 'h1F;
    for (int j = 0; j < 400; j++) begin
      if ($urandom_range(0, 19) == 0) dir = ~dir;
      if ($urandom_range(0, 9) == 0) r0 = int'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) r1 = int'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) r2 = int'($urandom_range(0, 31));
      applyStimulus("rand", $urandom_range(0, 9) != 0, dir, r0, r1, r2);
    end

    found = 0;
    for (int j = 0; j < 20 && found == 0; j++) begin
      applyStimulus("T5 seek", 1'b1, 1'b0, 'hF, 'hF, 'h1F);
      found = (m_blank[1] > 0) ? 1 : 0;
    end
    checkOutput("T5 u1 in blank before reset", 32'(blank1), 32'd1);
    #2 ireset = 1'b1;
    #1 resetModel();
    checkAll("T5 async");
    checkOutput("T5 u1 sel", 32'(sel1), 32'h1);
    checkOutput("T5 u1 idx", 32'(idx1), 32'h0);
    checkOutput("T5 u1 blank", 32'(blank1), 32'h0);
    checkOutput("T6 u2 sel", 32'(sel2), 32'h1E);
    @(negedge clk);
    ireset = 1'b0;
    repeat (12) applyStimulus("T5 restart", 1'b1, 1'b0, 'hF, 'hF, 'h1F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
